tff_counter: RTL

TFF_COUNTER -- requirements
Module: tff_counter

---
 rtl/tff_pkg.sv | 16 +
 rtl/tff_cell.sv | 35 +++
 rtl/tff_counter.sv | 91 +++++++++
 3 files changed

// File: rtl/tff_pkg.sv
// ---------------------------------------------------------------------------
// tff_pkg
// Shared constants for the T flip-flop counter slice.
//   DIR_UP / DIR_DOWN   : encoding of the Up direction input
//   DEFAULT_WIDTH       : default counter bit width
//   DEFAULT_MODULUS     : default number of count states
// ---------------------------------------------------------------------------
package tff_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 16;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// ---------------------------------------------------------------------------
// tff_cell
// Single negative-edge T flip-flop with asynchronous active-low reset.
// Ports:
//   Clock  : input, state changes on the falling edge
//   Resetn : input, asynchronous active-low reset (clears q)
//   t      : input, toggle enable sampled at the falling edge
//   q      : output, stored bit
// ---------------------------------------------------------------------------
module tff_cell (
    input  logic Clock,
    input  logic Resetn,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    // A T flip-flop is a D flip-flop fed with its own output XOR t.
    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(negedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : tff_cell

// File: rtl/tff_counter.sv
// ---------------------------------------------------------------------------
// tff_counter
// Modulo-MODULUS up/down counter built from WIDTH T flip-flops that update
// on the falling edge of Clock. The desired next count is computed here and
// each cell's T input is the XOR of its current bit and the next bit.
// Parameters:
//   WIDTH   : counter width (1..16)
//   MODULUS : number of count states 0..MODULUS-1 (2..2**WIDTH)
// Ports:
//   Clock  : input, falling edge is the active edge
//   Resetn : input, asynchronous active-low reset
//   En     : input, count enable
//   Up     : input, 1 = count up, 0 = count down
//   Load   : input, parallel-load strobe (TFF_COUNTER_LOAD_EN only)
//   D      : input [WIDTH], parallel-load value (TFF_COUNTER_LOAD_EN only)
//   Q      : output [WIDTH], current count
//   Tc     : output, combinational terminal-count flag
// Configuration macro:
//   TFF_COUNTER_LOAD_EN : when defined, adds Load/D and the parallel load.
// ---------------------------------------------------------------------------
module tff_counter
    import tff_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             En,
    input  logic             Up,
`ifdef TFF_COUNTER_LOAD_EN
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             Tc
);

    // MODULUS can be 2**WIDTH, so range checks use one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;
    logic             out_of_range;

    // Next-count selection. Priority: load, then recovery from an illegal
    // state, then counting, else hold. Toggles are the bits that differ.
    always_comb begin
        out_of_range = ({1'b0, count_q} >= MOD_EXT);
        count_d      = count_q;

        if (out_of_range) begin
            count_d = '0;
        end else if (En) begin
            if (Up == DIR_UP) begin
                count_d = (count_q == MAX_COUNT) ? '0 : count_q + WIDTH'(1);
            end else begin
                count_d = (count_q == '0) ? MAX_COUNT : count_q - WIDTH'(1);
            end
        end

`ifdef TFF_COUNTER_LOAD_EN
        if (Load) begin
            count_d = ({1'b0, D} >= MOD_EXT) ? MAX_COUNT : D;
        end
`endif

        toggle = count_q ^ count_d;
    end

    // Terminal count looks only at En, Up and the current count, so a load
    // in progress does not hide it.
    always_comb begin
        Tc = En && (((Up == DIR_UP) && (count_q == MAX_COUNT)) ||
                    ((Up == DIR_DOWN) && (count_q == '0)));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .Clock  (Clock),
            .Resetn (Resetn),
            .t      (toggle[i]),
            .q      (count_q[i])
        );
    end

    assign Q = count_q;

endmodule : tff_counter
